// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the burst memory controller.
// Contents: command byte codes, the write-acknowledge byte, the controller
// state enumeration and the state -> board LED encoding.
package mem_ctrl_pkg;

  localparam logic [7:0] CMD_READ   = 8'd48;
  localparam logic [7:0] CMD_WRITE  = 8'd49;
  localparam logic [7:0] CMD_BREAD  = 8'd50;
  localparam logic [7:0] CMD_BWRITE = 8'd51;
  localparam logic [7:0] ACK_BYTE   = 8'h06;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH_CMD,
    ST_READ_CMD,
    ST_FETCH_ADDR,
    ST_READ_ADDR,
    ST_FETCH_LEN,
    ST_READ_LEN,
    ST_FETCH_DATA,
    ST_READ_DATA,
    ST_WRITE_MEM,
    ST_READ_MEM_ADDR,
    ST_READ_MEM_VAL,
    ST_ECHO_VAL,
    ST_ACK
  } state_t;

  localparam logic [5:0] LED_IDLE = 6'b000001;
  localparam logic [5:0] LED_CMD  = 6'b000010;
  localparam logic [5:0] LED_ADDR = 6'b000100;
  localparam logic [5:0] LED_LEN  = 6'b001000;
  localparam logic [5:0] LED_DATA = 6'b010000;
  localparam logic [5:0] LED_READ = 6'b100000;

  function automatic logic [5:0] state_led(input state_t s);
    case (s)
      ST_FETCH_CMD, ST_READ_CMD:                         return LED_CMD;
      ST_FETCH_ADDR, ST_READ_ADDR:                       return LED_ADDR;
      ST_FETCH_LEN, ST_READ_LEN:                         return LED_LEN;
      ST_FETCH_DATA, ST_READ_DATA, ST_WRITE_MEM, ST_ACK: return LED_DATA;
      ST_READ_MEM_ADDR, ST_READ_MEM_VAL, ST_ECHO_VAL:    return LED_READ;
      default:                                           return LED_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mem_sync_ram.sv
// Single-port synchronous RAM with a registered (1-cycle) read.
// Ports: clk; we/wdata write addr on the rising edge; re loads rdata from
// addr on the rising edge. Contents are never reset.
module mem_sync_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_controller_burst.sv
// Byte-protocol memory controller between an RX FIFO (host bytes in) and a
// TX FIFO (bytes back to the host). Decodes READ/WRITE/BREAD/BWRITE packets
// against an internal mem_sync_ram; unknown command bytes are dropped.
// Ports: clk, rst_n (async active-low); rx_fifo_empty/rx_fifo_rd_en/din from
// the RX FIFO (din valid the cycle after rd_en); tx_fifo_full/tx_fifo_wr_en/
// dout to the TX FIFO; state_leds shows the current phase.
// Build option: define WRITE_ACK_EN to push ACK_BYTE after every completed
// WRITE or BWRITE packet.
module mem_controller_burst
  import mem_ctrl_pkg::*;
#(
  parameter int FIFO_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int ADDR_BYTES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_fifo_empty,
  input  logic                  tx_fifo_full,
  input  logic [FIFO_WIDTH-1:0] din,
  output logic                  rx_fifo_rd_en,
  output logic                  tx_fifo_wr_en,
  output logic [FIFO_WIDTH-1:0] dout,
  output logic [5:0]            state_leds
);

  localparam int AW = $clog2(MEM_DEPTH);

  state_t                state_q, state_d;
  logic                  is_wr_q, is_burst_q;
  logic [2:0]            abyte_q;
  logic [AW-1:0]         addr_q;
  logic [FIFO_WIDTH-1:0] cnt_q;
  logic [FIFO_WIDTH-1:0] data_q;
  logic                  ram_we, ram_re;
  logic [FIFO_WIDTH-1:0] ram_rdata;
  logic                  cmd_known, cmd_wr, cmd_burst;

  mem_sync_ram #(.WIDTH(FIFO_WIDTH), .DEPTH(MEM_DEPTH)) mem (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (addr_q),
    .wdata(data_q),
    .rdata(ram_rdata)
  );

  always_comb begin
    cmd_known = 1'b1;
    cmd_wr    = 1'b0;
    cmd_burst = 1'b0;
    case (din)
      FIFO_WIDTH'(CMD_READ):   ;
      FIFO_WIDTH'(CMD_WRITE):  cmd_wr = 1'b1;
      FIFO_WIDTH'(CMD_BREAD):  cmd_burst = 1'b1;
      FIFO_WIDTH'(CMD_BWRITE): begin cmd_wr = 1'b1; cmd_burst = 1'b1; end
      default:                 cmd_known = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    rx_fifo_rd_en = 1'b0;
    tx_fifo_wr_en = 1'b0;
    ram_we        = 1'b0;
    ram_re        = 1'b0;
    case (state_q)
      ST_IDLE:      state_d = ST_FETCH_CMD;
      ST_FETCH_CMD: if (!rx_fifo_empty) begin rx_fifo_rd_en = 1'b1; state_d = ST_READ_CMD; end
      ST_READ_CMD:  state_d = cmd_known ? ST_FETCH_ADDR : ST_IDLE;
      ST_FETCH_ADDR: if (!rx_fifo_empty) begin rx_fifo_rd_en = 1'b1; state_d = ST_READ_ADDR; end
      ST_READ_ADDR: begin
        if (abyte_q != 3'(ADDR_BYTES - 1)) state_d = ST_FETCH_ADDR;
        else if (is_burst_q)               state_d = ST_FETCH_LEN;
        else if (is_wr_q)                  state_d = ST_FETCH_DATA;
        else                               state_d = ST_READ_MEM_ADDR;
      end
      ST_FETCH_LEN: if (!rx_fifo_empty) begin rx_fifo_rd_en = 1'b1; state_d = ST_READ_LEN; end
      ST_READ_LEN:  state_d = is_wr_q ? ST_FETCH_DATA : ST_READ_MEM_ADDR;
      ST_FETCH_DATA: if (!rx_fifo_empty) begin rx_fifo_rd_en = 1'b1; state_d = ST_READ_DATA; end
      ST_READ_DATA: state_d = ST_WRITE_MEM;
      ST_WRITE_MEM: begin
        ram_we = 1'b1;
        if (cnt_q == '0) begin
`ifdef WRITE_ACK_EN
          state_d = ST_ACK;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          state_d = ST_FETCH_DATA;
        end
      end
      ST_READ_MEM_ADDR: begin ram_re = 1'b1; state_d = ST_READ_MEM_VAL; end
      ST_READ_MEM_VAL:  state_d = ST_ECHO_VAL;
      ST_ECHO_VAL: if (!tx_fifo_full) begin
        tx_fifo_wr_en = 1'b1;
        state_d = (cnt_q == '0) ? ST_IDLE : ST_READ_MEM_ADDR;
      end
`ifdef WRITE_ACK_EN
      ST_ACK: if (!tx_fifo_full) begin tx_fifo_wr_en = 1'b1; state_d = ST_IDLE; end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // cnt_q holds transfers still owed after the current one; single packets
  // leave it at zero so they share the burst loop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      is_wr_q    <= 1'b0;
      is_burst_q <= 1'b0;
      abyte_q    <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_READ_CMD: begin
          is_wr_q    <= cmd_wr;
          is_burst_q <= cmd_burst;
          abyte_q    <= '0;
          addr_q     <= '0;
          cnt_q      <= '0;
        end
        // MSB-first shift; bits above the RAM index fall off the top.
        ST_READ_ADDR: begin
          addr_q  <= (addr_q << FIFO_WIDTH) | AW'(din);
          abyte_q <= abyte_q + 3'd1;
        end
        ST_READ_LEN:  cnt_q  <= din;
        ST_READ_DATA: data_q <= din;
        ST_WRITE_MEM: if (cnt_q != '0) begin
          cnt_q  <= cnt_q - 1'b1;
          addr_q <= addr_q + 1'b1;
        end
        // RAM read stage boundary: rdata is valid one cycle after re.
        ST_READ_MEM_VAL: data_q <= ram_rdata;
        ST_ECHO_VAL: if (!tx_fifo_full && cnt_q != '0) begin
          cnt_q  <= cnt_q - 1'b1;
          addr_q <= addr_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef WRITE_ACK_EN
  assign dout = (state_q == ST_ACK) ? FIFO_WIDTH'(ACK_BYTE) : data_q;
`else
  assign dout = data_q;
`endif

  assign state_leds = state_led(state_q);

endmodule

// File: tb/tb_mem_controller_burst.sv
// Directed bench for mem_controller_burst: behavioural RX/TX FIFOs around a
// default-parameter instance, plus a 2-address-byte, 1024-word instance.
module tb_mem_controller_burst;

  localparam int TX_DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_fifo_empty, tx_fifo_full, rx_fifo_rd_en, tx_fifo_wr_en;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic [5:0] state_leds;

  logic       rx2_empty, rx2_rd_en, tx2_wr_en;
  logic       tx2_full = 1'b0;
  logic [7:0] din2 = 8'h00;
  logic [7:0] dout2;
  logic [5:0] leds2;

  logic [7:0] rx_mem [256];
  logic [7:0] tx_mem [256];
  logic [7:0] rx2_mem [256];
  int rx_wr = 0, rx_rd = 0, tx_wr = 0, tx_rd = 0;
  int rx2_wr = 0, rx2_rd = 0, tx2_cnt = 0;
  logic [7:0] tx2_last = 8'h00;
  int cyc = 0, last_rd_cyc = 0, last_wr_cyc = 0, spur_rd = 0, spur_wr = 0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign rx_fifo_empty = (rx_wr == rx_rd);
  assign tx_fifo_full  = ((tx_wr - tx_rd) >= TX_DEPTH);
  assign rx2_empty     = (rx2_wr == rx2_rd);

  mem_controller_burst mem_ctrl (
    .clk(clk), .rst_n(rst_n), .rx_fifo_empty(rx_fifo_empty), .tx_fifo_full(tx_fifo_full),
    .din(din), .rx_fifo_rd_en(rx_fifo_rd_en), .tx_fifo_wr_en(tx_fifo_wr_en),
    .dout(dout), .state_leds(state_leds)
  );

  mem_controller_burst #(.FIFO_WIDTH(8), .MEM_DEPTH(1024), .ADDR_BYTES(2)) mem_ctrl2 (
    .clk(clk), .rst_n(rst_n), .rx_fifo_empty(rx2_empty), .tx_fifo_full(tx2_full),
    .din(din2), .rx_fifo_rd_en(rx2_rd_en), .tx_fifo_wr_en(tx2_wr_en),
    .dout(dout2), .state_leds(leds2)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rx_fifo_rd_en) begin
      last_rd_cyc <= cyc;
      if (rx_fifo_empty) spur_rd <= spur_rd + 1;
      else begin
        din   <= rx_mem[rx_rd[7:0]];
        rx_rd <= rx_rd + 1;
      end
    end
    if (tx_fifo_wr_en) begin
      last_wr_cyc <= cyc;
      if (tx_fifo_full) spur_wr <= spur_wr + 1;
      else begin
        tx_mem[tx_wr[7:0]] <= dout;
        tx_wr <= tx_wr + 1;
      end
    end
    if (rx2_rd_en && !rx2_empty) begin
      din2   <= rx2_mem[rx2_rd[7:0]];
      rx2_rd <= rx2_rd + 1;
    end
    if (tx2_wr_en) begin
      tx2_last <= dout2;
      tx2_cnt  <= tx2_cnt + 1;
    end
  end

  task automatic push_rx(input logic [7:0] b);
    rx_mem[rx_wr[7:0]] = b;
    rx_wr = rx_wr + 1;
  endtask

  task automatic push_rx2(input logic [7:0] b);
    rx2_mem[rx2_wr[7:0]] = b;
    rx2_wr = rx2_wr + 1;
  endtask

  task automatic pop_tx(input int budget, output logic [7:0] got, output bit ok);
    int n = 0;
    while (tx_wr == tx_rd && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok  = (tx_wr != tx_rd);
    got = 8'h00;
    if (ok) begin
      got   = tx_mem[tx_rd[7:0]];
      tx_rd = tx_rd + 1;
    end
  endtask

  // Discards whatever the controller has pushed (write acknowledges, if built in).
  task automatic flush_tx();
    repeat (3) @(negedge clk);
    tx_rd = tx_wr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rx_fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", rx_fifo_rd_en); end
    checks++; if (tx_fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", tx_fifo_wr_en); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", dout); end
    checks++; if (state_leds !== 6'b000001) begin errors++; $display("FAIL reset_leds: got %b want 000001", state_leds); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    logic [7:0] got;
    bit ok;
    push_rx(8'd49); push_rx(8'd10); push_rx(8'd65);
    repeat (10) @(negedge clk);
    checks++; if (mem_ctrl.mem.mem[10] !== 8'd65) begin errors++; $display("FAIL wr_mem10: got %0d want 65", mem_ctrl.mem.mem[10]); end
    flush_tx();
    push_rx(8'd48); push_rx(8'd10);
    pop_tx(40, got, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rd_mem10: no TX byte, want 65"); end
    else if (got !== 8'd65) begin errors++; $display("FAIL rd_mem10: got %0d want 65", got); end
    checks++; if (last_wr_cyc - last_rd_cyc != 4) begin errors++; $display("FAIL rd_latency: got %0d want 4 cycles fetch->push", last_wr_cyc - last_rd_cyc); end
    repeat (2) @(negedge clk);
    checks++; if (state_leds !== 6'b000010) begin errors++; $display("FAIL rd_done_leds: got %b want 000010", state_leds); end
  endtask

  task automatic test_burst_wrap();
    logic [7:0] pkt [7] = '{8'd51, 8'd254, 8'd3, 8'd1, 8'd2, 8'd3, 8'd4};
    int addrs [4] = '{254, 255, 0, 1};
    logic [7:0] got;
    bit ok;
    foreach (pkt[i]) push_rx(pkt[i]);
    repeat (30) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_ctrl.mem.mem[addrs[i]] !== 8'(i + 1)) begin
        errors++; $display("FAIL bwr_mem%0d: got %0d want %0d", addrs[i], mem_ctrl.mem.mem[addrs[i]], i + 1);
      end
    end
    flush_tx();
    push_rx(8'd50); push_rx(8'd254); push_rx(8'd3);
    for (int i = 0; i < 4; i++) begin
      pop_tx(40, got, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL brd_%0d: no TX byte, want %0d", i, i + 1); end
      else if (got !== 8'(i + 1)) begin errors++; $display("FAIL brd_%0d: got %0d want %0d", i, got, i + 1); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got;
    bit ok;
    push_rx(8'd51); push_rx(8'd10); push_rx(8'd9);
    for (int i = 0; i < 10; i++) push_rx(8'(65 + i));
    repeat (45) @(negedge clk);
    flush_tx();
    for (int i = 0; i < 10; i++) begin push_rx(8'd48); push_rx(8'(10 + i)); end
    repeat (120) @(negedge clk);
    checks++; if (tx_wr - tx_rd != 8) begin errors++; $display("FAIL bp_tx_level: got %0d want 8", tx_wr - tx_rd); end
    checks++; if (state_leds !== 6'b100000) begin errors++; $display("FAIL bp_leds: got %b want 100000", state_leds); end
    checks++; if (dout !== 8'd73) begin errors++; $display("FAIL bp_dout_hold: got %0d want 73", dout); end
    checks++; if (spur_wr != 0) begin errors++; $display("FAIL bp_wr_when_full: got %0d want 0", spur_wr); end
    for (int i = 0; i < 10; i++) begin
      pop_tx(40, got, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL bp_val%0d: no TX byte, want %0d", i, 65 + i); end
      else if (got !== 8'(65 + i)) begin errors++; $display("FAIL bp_val%0d: got %0d want %0d", i, got, 65 + i); end
    end
  endtask

  task automatic test_rx_starvation();
    push_rx(8'd49);
    repeat (5) @(negedge clk);
    checks++; if (state_leds !== 6'b000100) begin errors++; $display("FAIL starve_addr_leds: got %b want 000100", state_leds); end
    push_rx(8'd20);
    repeat (5) @(negedge clk);
    checks++; if (state_leds !== 6'b010000) begin errors++; $display("FAIL starve_data_leds: got %b want 010000", state_leds); end
    push_rx(8'd66);
    repeat (10) @(negedge clk);
    checks++; if (mem_ctrl.mem.mem[20] !== 8'd66) begin errors++; $display("FAIL starve_mem20: got %0d want 66", mem_ctrl.mem.mem[20]); end
    checks++; if (spur_rd != 0) begin errors++; $display("FAIL starve_rd_when_empty: got %0d want 0", spur_rd); end
    flush_tx();
  endtask

  task automatic test_garbage_reset();
    push_rx(8'd7); push_rx(8'd49); push_rx(8'd30); push_rx(8'd67);
    repeat (25) @(negedge clk);
    checks++; if (mem_ctrl.mem.mem[30] !== 8'd67) begin errors++; $display("FAIL garbage_mem30: got %0d want 67", mem_ctrl.mem.mem[30]); end
    flush_tx();
    push_rx(8'd51); push_rx(8'd30);
    repeat (10) @(negedge clk);
    checks++; if (state_leds !== 6'b001000) begin errors++; $display("FAIL midburst_leds: got %b want 001000", state_leds); end
    rst_n = 1'b0;
    #1;
    checks++; if (rx_fifo_rd_en !== 1'b0) begin errors++; $display("FAIL async_rst_rd_en: got %b want 0", rx_fifo_rd_en); end
    checks++; if (tx_fifo_wr_en !== 1'b0) begin errors++; $display("FAIL async_rst_wr_en: got %b want 0", tx_fifo_wr_en); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL async_rst_dout: got %h want 00", dout); end
    checks++; if (state_leds !== 6'b000001) begin errors++; $display("FAIL async_rst_leds: got %b want 000001", state_leds); end
    checks++; if (mem_ctrl.mem.mem[30] !== 8'd67) begin errors++; $display("FAIL rst_keeps_mem30: got %0d want 67", mem_ctrl.mem.mem[30]); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_addr_bytes2();
    push_rx2(8'd49); push_rx2(8'h03); push_rx2(8'hFF); push_rx2(8'd88);
    repeat (25) @(negedge clk);
    checks++; if (mem_ctrl2.mem.mem[1023] !== 8'd88) begin errors++; $display("FAIL a2_mem1023: got %0d want 88", mem_ctrl2.mem.mem[1023]); end
`ifdef WRITE_ACK_EN
    checks++; if (tx2_cnt != 1) begin errors++; $display("FAIL a2_ack_count: got %0d want 1", tx2_cnt); end
    checks++; if (tx2_last !== 8'h06) begin errors++; $display("FAIL a2_ack_byte: got %h want 06", tx2_last); end
`else
    checks++; if (tx2_cnt != 0) begin errors++; $display("FAIL a2_no_tx: got %0d want 0", tx2_cnt); end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_burst_wrap();
    test_back_to_back();
    test_rx_starvation();
    test_garbage_reset();
    test_addr_bytes2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
